load_register: RTL and testbench

//   Generic WIDTH-bit storage register with a synchronous load enable and an asynchronous reset.
//   It is the basic state element for the pipeline and its predictors, e.g. branch history

---
 rtl/rv32i_types.sv | 6 +
 rtl/reg_parity_gen.sv | 16 +
 rtl/load_register.sv | 48 ++++
 tb/tb_load_register.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I type definitions used by the pipeline and predictor state elements.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

endpackage

// File: rtl/reg_parity_gen.sv
// Parity helper for load_register.
// Generates the parity bit to store on a load, and flags a mismatch between the stored data and the stored parity.
module reg_parity_gen #(
  parameter int width = 32
) (
  input  logic [width-1:0] data_in,
  input  logic [width-1:0] data_q,
  input  logic             parity_q,
  output logic             parity_next,
  output logic             parity_err
);

  assign parity_next = ^data_in;
  assign parity_err  = (^data_q) != parity_q;

endmodule

// File: rtl/load_register.sv
// Generic width-bit register with synchronous load and asynchronous active-high reset.
// Optional hidden parity bit and parity_err output when LOAD_REGISTER_PARITY_EN is defined.
module load_register
  import rv32i_types::*;
#(
  parameter int               width     = 32,
  parameter logic [width-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] in,
`ifdef LOAD_REGISTER_PARITY_EN
  output logic             parity_err,
`endif
  output logic [width-1:0] out
);

  // The initializer gives a known value when reset is tied low.
  logic [width-1:0] data = RESET_VAL;

  // Ternary rather than if: an X on load corrupts data instead of silently holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) data <= RESET_VAL;
    else       data <= load ? in : data;
  end

  assign out = data;

`ifdef LOAD_REGISTER_PARITY_EN
  logic parity_q = ^RESET_VAL;
  logic parity_next;

  reg_parity_gen #(.width(width)) u_parity (
    .data_in     (in),
    .data_q      (out),
    .parity_q    (parity_q),
    .parity_next (parity_next),
    .parity_err  (parity_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) parity_q <= ^RESET_VAL;
    else       parity_q <= load ? parity_next : parity_q;
  end
`endif

endmodule

// File: tb/tb_load_register.sv
// Directed self-checking bench for load_register: 32-bit instance with reset and a
// 3-bit shift-history instance with reset tied low.
module tb_load_register;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [31:0] din;
  logic [31:0] dout;

  logic [2:0]  sh_in;
  logic        sh_load;
  logic [2:0]  sh_out;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LOAD_REGISTER_PARITY_EN
  logic perr;
  logic sh_perr;
`endif

  always #5 clk = ~clk;

  load_register #(.width(32), .RESET_VAL(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .in    (din),
`ifdef LOAD_REGISTER_PARITY_EN
    .parity_err (perr),
`endif
    .out   (dout)
  );

  load_register #(.width(3), .RESET_VAL(3'b000)) dut_sh (
    .clk   (clk),
    .reset (1'b0),
    .load  (sh_load),
    .in    (sh_in),
`ifdef LOAD_REGISTER_PARITY_EN
    .parity_err (sh_perr),
`endif
    .out   (sh_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    load    = 1'b0;
    din     = 32'h0;
    sh_load = 1'b0;
    sh_in   = 3'b000;
    #1;
    check("shift_time_zero", {29'h0, sh_out}, 32'h0);
    check("reset_initial", dout, 32'h0);

    // Release reset and load 0x1234.
    tick();
    reset = 1'b0;
    load  = 1'b1;
    din   = 32'h1234;
    tick();
    check("load_1234", dout, 32'h1234);
    load = 1'b0;
    din  = 32'hFFFF_0000;
    tick();
    check("hold_1234", dout, 32'h1234);

    // Reset pulse in the low phase of clk, no edge in between.
    @(negedge clk);
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("async_reset_mid_cycle", dout, 32'h0);

    // Load DEADBEEF: old value visible until the edge.
    load = 1'b1;
    din  = 32'hDEAD_BEEF;
    #1;
    check("no_bypass_before_edge", dout, 32'h0);
    tick();
    check("load_deadbeef", dout, 32'hDEAD_BEEF);

    // Hold with toggling data.
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = (i % 2 == 0) ? 32'h0 : 32'hFFFF_FFFF;
      tick();
      check($sformatf("hold_edge%0d", i), dout, 32'hDEAD_BEEF);
    end

    // Reset priority over load.
    reset = 1'b1;
    load  = 1'b1;
    din   = 32'hA5A5_A5A5;
    #1;
    check("reset_immediate", dout, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_priority_edge%0d", i), dout, 32'h0);
    end
    reset = 1'b0;
    din   = 32'h5;
    tick();
    check("first_edge_after_release", dout, 32'h5);
    load = 1'b0;

    // Shift-register use on the 3-bit instance: b = 1,1,0.
    sh_load = 1'b1;
    sh_in = {sh_out[1:0], 1'b1};
    tick();
    check("shift_001", {29'h0, sh_out}, 32'h1);
    sh_in = {sh_out[1:0], 1'b1};
    tick();
    check("shift_011", {29'h0, sh_out}, 32'h3);
    sh_in = {sh_out[1:0], 1'b0};
    tick();
    check("shift_110", {29'h0, sh_out}, 32'h6);
    sh_load = 1'b0;
    sh_in   = 3'b111;
    tick();
    check("shift_hold", {29'h0, sh_out}, 32'h6);

`ifdef LOAD_REGISTER_PARITY_EN
    load = 1'b1;
    din  = 32'h1;
    tick();
    load = 1'b0;
    check("parity_load_1_data", dout, 32'h1);
    check("parity_ok", {31'h0, perr}, 32'h0);
    force dut.data = 32'h3;
    #1;
    check("parity_upset", {31'h0, perr}, 32'h1);
    release dut.data;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    check("parity_after_reset", {31'h0, perr}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
